// File: rtl/fir_ctrl.sv
// Load-and-run sequencer for a FIR core: streams coefficients then samples into
// the core memories, runs the core, forwards its outputs and guards against stalls.
module fir_ctrl #(
  parameter int NCOEF = 64,
  parameter int NSAMP = 16384,
  parameter int NOUT  = 16447,
  parameter int TMO   = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] out_data,
  output logic        out_valid,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        core_rstn,
  output logic [15:0] core_din,
  output logic [13:0] core_addr,
  output logic        core_cload,
  output logic        core_dload,
  output logic        core_s,
  input  logic [15:0] core_dout,
  input  logic        core_valid,
  input  logic        core_done
);

  localparam int OW = $clog2(NOUT + 1);
  localparam int WW = $clog2(TMO + 1);
  localparam logic [13:0]   C_LAST = 14'(NCOEF - 1);
  localparam logic [13:0]   S_LAST = 14'(NSAMP - 1);
  localparam logic [OW-1:0] O_LAST = OW'(NOUT - 1);
  localparam logic [WW-1:0] T_LAST = WW'(TMO - 1);

  typedef enum logic [2:0] {IDLE, LOAD_C, LOAD_D, RUN, FIN} state_t;

  state_t        state_q, state_d;
  logic [13:0]   addr_q, addr_d;
  logic [OW-1:0] ocnt_q, ocnt_d;
  logic [WW-1:0] wdog_q, wdog_d;
  logic [15:0]   din_q, din_d;
  logic [13:0]   waddr_q, waddr_d;
  logic          cload_q, cload_d;
  logic          dload_q, dload_d;
  logic [15:0]   odata_q, odata_d;
  logic          ovalid_q, ovalid_d;
  logic          err_q, err_d;
  logic          ready;
  logic          accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      ocnt_q   <= '0;
      wdog_q   <= '0;
      din_q    <= '0;
      waddr_q  <= '0;
      cload_q  <= 1'b1;
      dload_q  <= 1'b1;
      odata_q  <= '0;
      ovalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      ocnt_q   <= ocnt_d;
      wdog_q   <= wdog_d;
      din_q    <= din_d;
      waddr_q  <= waddr_d;
      cload_q  <= cload_d;
      dload_q  <= dload_d;
      odata_q  <= odata_d;
      ovalid_q <= ovalid_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    ocnt_d   = ocnt_q;
    wdog_d   = wdog_q;
    din_d    = din_q;
    waddr_d  = waddr_q;
    cload_d  = 1'b1;
    dload_d  = 1'b1;
    odata_d  = odata_q;
    ovalid_d = 1'b0;
    err_d    = 1'b0;

    ready  = (state_q == LOAD_C || state_q == LOAD_D) && !abort;
    accept = ready && in_valid;

    // Accepted words are presented to the core memories on the following cycle.
    if (accept) begin
      din_d   = in_data;
      waddr_d = addr_q;
      cload_d = (state_q != LOAD_C);
      dload_d = (state_q != LOAD_D);
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD_C;
          addr_d  = '0;
        end
      end
      LOAD_C: begin
        if (accept) begin
          if (addr_q == C_LAST) begin
            state_d = LOAD_D;
            addr_d  = '0;
          end else begin
            addr_d = addr_q + 14'd1;
          end
        end
      end
      LOAD_D: begin
        if (accept) begin
          if (addr_q == S_LAST) begin
            state_d = RUN;
            addr_d  = '0;
            ocnt_d  = '0;
            wdog_d  = '0;
          end else begin
            addr_d = addr_q + 14'd1;
          end
        end
      end
      RUN: begin
        if (core_valid) begin
          ovalid_d = 1'b1;
          odata_d  = core_dout;
          ocnt_d   = ocnt_q + OW'(1);
          wdog_d   = '0;
        end
        // Completion wins over a watchdog expiry landing on the same cycle.
        if ((core_valid && ocnt_q == O_LAST) || core_done) begin
          state_d = FIN;
        end else if (!core_valid && wdog_q == T_LAST) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else if (!core_valid) begin
          wdog_d = wdog_q + WW'(1);
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (abort) begin
      state_d  = IDLE;
      addr_d   = '0;
      ocnt_d   = '0;
      wdog_d   = '0;
      ovalid_d = 1'b0;
      err_d    = 1'b0;
    end
  end

  assign in_ready   = ready;
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == FIN) && !abort;
  assign err        = err_q;
  assign core_rstn  = (state_q == RUN) || (state_q == FIN);
  assign core_s     = (state_q == RUN);
  assign core_din   = din_q;
  assign core_addr  = waddr_q;
  assign core_cload = cload_q;
  assign core_dload = dload_q;
  assign out_data   = odata_q;
  assign out_valid  = ovalid_q;

endmodule

// File: tb/tb_fir_ctrl.sv
// Bench for fir_ctrl: directed job scenarios plus randomized traffic, all checked
// every cycle against a job-level model built from word and output counts.
module tb_fir_ctrl;
  localparam int NC = 4;
  localparam int NS = 8;
  localparam int NO = 11;
  localparam int TM = 16;

  logic        clk, rst, start, abort, in_valid, core_valid, core_done;
  logic [15:0] in_data, core_dout;
  logic        in_ready, out_valid, busy, done, err, core_rstn;
  logic        core_cload, core_dload, core_s;
  logic [15:0] out_data, core_din;
  logic [13:0] core_addr;

  fir_ctrl #(.NCOEF(NC), .NSAMP(NS), .NOUT(NO), .TMO(TM)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .busy(busy), .done(done), .err(err),
    .core_rstn(core_rstn), .core_din(core_din), .core_addr(core_addr),
    .core_cload(core_cload), .core_dload(core_dload), .core_s(core_s),
    .core_dout(core_dout), .core_valid(core_valid), .core_done(core_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model: job phase (0 idle, 1 loading, 2 running, 3 finishing) plus counts.
  int m_job = 0, m_words = 0, m_outs = 0, m_quiet = 0;
  bit m_err = 0, pw = 0, pc = 0, po = 0;
  int paddr = 0;
  logic [15:0] pdata = '0, podata = '0;
  bit last_acc = 0;
  int n_cl = 0, n_dl = 0, n_done = 0, n_err = 0, n_ov = 0, ov_sum = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_job = 0; m_words = 0; m_outs = 0; m_quiet = 0;
    m_err = 0; pw = 0; po = 0;
  endtask

  task automatic model_step();
    bit acc;
    acc = (m_job == 1) && !abort && in_valid;
    last_acc = acc;
    po = (m_job == 2) && core_valid && !abort;
    podata = core_dout;
    pw = acc;
    if (acc) begin
      pc = (m_words < NC);
      paddr = pc ? m_words : m_words - NC;
      pdata = in_data;
    end
    m_err = 0;
    if (abort) begin
      m_job = 0; m_words = 0; m_outs = 0; m_quiet = 0;
    end else begin
      case (m_job)
        0: if (start) begin m_job = 1; m_words = 0; end
        1: if (acc) begin
             m_words++;
             if (m_words == NC + NS) begin m_job = 2; m_outs = 0; m_quiet = 0; end
           end
        2: if (core_valid) begin
             m_outs++; m_quiet = 0;
             if (m_outs == NO || core_done) m_job = 3;
           end else if (core_done) begin
             m_job = 3;
           end else begin
             m_quiet++;
             if (m_quiet == TM) begin m_job = 0; m_err = 1; end
           end
        default: m_job = 0;
      endcase
    end
  endtask

  // One cycle: compare at the falling edge, advance the model, resume after the rising edge.
  task automatic tick();
    @(negedge clk);
    last_acc = 0;
    if (rst) begin
      model_reset();
      chk("rst_busy", busy, 0);       chk("rst_in_ready", in_ready, 0);
      chk("rst_done", done, 0);       chk("rst_err", err, 0);
      chk("rst_out_valid", out_valid, 0); chk("rst_out_data", out_data, 0);
      chk("rst_core_rstn", core_rstn, 0); chk("rst_core_s", core_s, 0);
      chk("rst_core_din", core_din, 0);   chk("rst_core_addr", core_addr, 0);
      chk("rst_cload", core_cload, 1);    chk("rst_dload", core_dload, 1);
    end else begin
      chk("busy", busy, m_job != 0);
      chk("in_ready", in_ready, (m_job == 1) && !abort);
      chk("core_rstn", core_rstn, m_job >= 2);
      chk("core_s", core_s, m_job == 2);
      chk("done", done, (m_job == 3) && !abort);
      chk("err", err, m_err);
      chk("cload", core_cload, !(pw && pc));
      chk("dload", core_dload, !(pw && !pc));
      chk("out_valid", out_valid, po);
      if (pw) begin
        chk("core_din", core_din, pdata);
        chk("core_addr", core_addr, paddr);
      end
      if (po) chk("out_data", out_data, podata);
      if (!core_cload) n_cl++;
      if (!core_dload) n_dl++;
      if (done) n_done++;
      if (err) n_err++;
      if (out_valid) begin n_ov++; ov_sum += int'(out_data); end
      model_step();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  // mode 0: back-to-back, 1: alternate valid, 2: random valid
  task automatic send_words(input int n, input int mode);
    int k = 0;
    for (int g = 0; g < 200 && k < n; g++) begin
      in_valid = (mode == 0) ? 1'b1 : (mode == 1) ? ((g % 2) == 0) : ($urandom_range(1, 0) == 1);
      in_data = 16'($urandom);
      tick();
      if (last_acc) k++;
    end
    in_valid = 1'b0;
    if (k < n) chk("send_budget", k, n);
  endtask

  task automatic run_outputs(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      core_valid = 1'b1; core_dout = 16'(base + i); tick();
    end
    core_valid = 1'b0;
  endtask

  int s_cl, s_dl, s_done, s_err, s_ov, s_sum;
  task automatic snap();
    s_cl = n_cl; s_dl = n_dl; s_done = n_done; s_err = n_err; s_ov = n_ov; s_sum = ov_sum;
  endtask

  int mode;
  initial begin
    rst = 1'b1; start = 0; abort = 0; in_valid = 0; in_data = '0;
    core_valid = 0; core_dout = '0; core_done = 0;
    #1;
    idle(3);
    rst = 1'b0;
    idle(2);

    // Full job, back-to-back load, outputs 1..11
    snap(); do_start(); send_words(12, 0); run_outputs(11, 1); idle(3);
    chk("A_cload_cycles", n_cl - s_cl, 4);
    chk("A_dload_cycles", n_dl - s_dl, 8);
    chk("A_done_pulses", n_done - s_done, 1);
    chk("A_outputs", n_ov - s_ov, 11);
    chk("A_out_sum", ov_sum - s_sum, 66);
    chk("A_busy_after", busy, 0);

    // Stalled load
    snap(); do_start(); send_words(12, 1); run_outputs(11, 100); idle(3);
    chk("B_writes", (n_cl - s_cl) + (n_dl - s_dl), 12);
    chk("B_done_pulses", n_done - s_done, 1);

    // Watchdog
    snap(); do_start(); send_words(12, 0); idle(20);
    chk("C_err_pulses", n_err - s_err, 1);
    chk("C_done_pulses", n_done - s_done, 0);
    chk("C_core_rstn", core_rstn, 0);
    chk("C_busy", busy, 0);

    // Abort during sample load, then a fresh job
    snap(); do_start(); send_words(9, 0);
    abort = 1'b1; in_valid = 1'b1; tick(); abort = 1'b0; in_valid = 1'b0;
    chk("D_busy_after_abort", busy, 0);
    chk("D_in_ready_after_abort", in_ready, 0);
    idle(2);
    chk("D_done_after_abort", n_done - s_done, 0);
    snap(); do_start(); send_words(12, 0); run_outputs(11, 7); idle(3);
    chk("D_restart_cload", n_cl - s_cl, 4);
    chk("D_restart_done", n_done - s_done, 1);

    // Early core_done; start while running is ignored
    snap(); do_start(); send_words(12, 0); run_outputs(6, 20);
    start = 1'b1; tick(); start = 1'b0;
    core_done = 1'b1; tick(); core_done = 1'b0; idle(3);
    chk("E_done_pulses", n_done - s_done, 1);
    chk("E_outputs", n_ov - s_ov, 6);
    chk("E_err_pulses", n_err - s_err, 0);

    // Randomized traffic with a mid-run reset
    mode = 0;
    for (int c = 0; c < 1500; c++) begin
      if (c % 64 == 0) mode = $urandom_range(2, 0);
      start      = ($urandom_range(5, 0) == 0);
      abort      = ($urandom_range(60, 0) == 0);
      in_valid   = ($urandom_range(2, 0) != 0);
      in_data    = 16'($urandom);
      core_valid = (mode == 0) ? ($urandom_range(40, 0) == 0) : ($urandom_range(3, 0) != 0);
      core_dout  = 16'($urandom);
      core_done  = ($urandom_range(40, 0) == 0);
      rst        = (c >= 700 && c < 702);
      tick();
    end
    rst = 0; start = 0; abort = 0; in_valid = 0; core_valid = 0; core_done = 0;
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fir_ctrl.md
FIR_CTRL -- requirements
Module: fir_ctrl

Interface
REQ-001 Parameter NCOEF, default 64: number of coefficients written to the core's CMEM.
REQ-002 Parameter NSAMP, default 16384: number of input samples written to the core's IMEM.
REQ-003 Parameter NOUT, default 16447 (NSAMP+NCOEF-1): number of core outputs collected per run.
REQ-004 Parameter TMO, default 1024: cycle limit between consecutive core outputs while running.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 start  in  1  one-cycle request to begin a load-and-run job; honoured only in IDLE.
REQ-008 abort  in  1  level; forces return to IDLE from any state.
REQ-009 in_data  in  16  coefficient/sample stream word.
REQ-010 in_valid  in  1  in_data valid.
REQ-011 in_ready  out  1  controller accepts in_data this cycle.
REQ-012 out_data  out  16  filtered sample forwarded from the core.
REQ-013 out_valid  out  1  out_data valid, one cycle per sample.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 done  out  1  one-cycle pulse on successful job completion.
REQ-016 err  out  1  one-cycle pulse on timeout.
REQ-017 core_rstn  out  1  core reset, active-low.
REQ-018 core_din  out  16  write data to core memories.
REQ-019 core_addr  out  14  write address to core memories.
REQ-020 core_cload  out  1  active-low CMEM write strobe.
REQ-021 core_dload  out  1  active-low IMEM write strobe.
REQ-022 core_s  out  1  core run enable.
REQ-023 core_dout  in  16  core output sample.
REQ-024 core_valid  in  1  core_dout valid.
REQ-025 core_done  in  1  core reports end of processing.

Function
REQ-026 The FSM SHALL have states IDLE, LOAD_C, LOAD_D, RUN, FIN; IDLE->LOAD_C on start; LOAD_C->LOAD_D after NCOEF accepted words; LOAD_D->RUN after NSAMP accepted words; RUN->FIN after NOUT outputs or core_done; FIN->IDLE after one cycle.
REQ-027 in_ready SHALL equal 1 exactly in LOAD_C and LOAD_D, and 0 during abort.
REQ-028 A word accepted (in_valid&in_ready) in cycle N SHALL appear on core_din with core_addr = word index (0-based, per phase) and the phase strobe low for exactly cycle N+1; strobes SHALL be high otherwise.
REQ-029 Address counter SHALL reset to 0 on entering LOAD_C and on entering LOAD_D; no wrap occurs within a phase.
REQ-030 core_rstn SHALL be 0 in IDLE, LOAD_C, LOAD_D and 1 in RUN and FIN; core_s SHALL be 1 only in RUN.
REQ-031 In RUN, out_data/out_valid SHALL be core_dout/core_valid registered one cycle; output counter increments per core_valid.
REQ-032 The NOUT-th core_valid SHALL be forwarded and cause RUN->FIN; core_valid outside RUN SHALL be ignored.
REQ-033 core_done in RUN SHALL cause RUN->FIN even if fewer than NOUT outputs were seen; done pulses in FIN in both cases.
REQ-034 A watchdog SHALL count RUN cycles since the last core_valid (or RUN entry); reaching TMO SHALL pulse err and go to IDLE without done.
REQ-035 abort SHALL take priority over every other transition: next state IDLE, counters cleared, no done/err pulse.
REQ-036 start outside IDLE SHALL be ignored.
REQ-037 in_valid stalls SHALL hold the FSM and counters; no strobe is issued for a stalled cycle.

Reset
REQ-038 On rst: state IDLE, counters 0, in_ready=0, out_valid=0, out_data=0, busy=0, done=0, err=0, core_rstn=0, core_din=0, core_addr=0, core_cload=1, core_dload=1, core_s=0.
REQ-039 rst asserted mid-job SHALL produce the REQ-038 values asynchronously; the next job requires a new start.

Verification (NCOEF=4, NSAMP=8, NOUT=11, TMO=16)
REQ-040 start, stream 12 words back-to-back -> cload low 4 cycles addr 0..3, then dload low 8 cycles addr 0..7, then core_s=1, core_rstn=1.
REQ-041 In RUN, 11 core_valid pulses with values 1..11 -> out_data 1..11 one cycle later, done pulses once, busy falls next cycle.
REQ-042 in_valid toggled 1/0 during load -> strobes only for accepted words, addresses contiguous, 12 writes total.
REQ-043 In RUN, no core_valid for 16 cycles -> err pulse, done stays 0, state IDLE, core_rstn=0.
REQ-044 abort during LOAD_D at addr 5 -> IDLE next cycle, in_ready=0, no done; fresh start restarts at CMEM addr 0.
REQ-045 core_done after 6 outputs -> FIN, done pulse; start during RUN ignored.
